// File: rtl/fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter
//   Round-robin arbiter that shares one fifo write port among N_REQ producers.
//   One producer owns the port at a time (a "grant"). Up to MAX_BURST of its
//   words are forwarded per grant. Then the port is re-arbitrated after one
//   idle cycle. Fifo-full back-pressure stalls the owner for as long as it
//   lasts, and the owner keeps its grant while stalled.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-low reset
//   req        in   [N_REQ]       req[i]=1: producer i presents a word on din
//   din        in   [N_REQ*BITS]  producer i word on din[i*BITS +: BITS]
//   ack        out  [N_REQ]       producer i word written this cycle
//   grant      out  [N_REQ]       registered one-hot owner, zero when idle
//   fifo_push  out  push strobe to the fifo
//   fifo_din   out  [BITS]        data to the fifo
//   fifo_full  in   fifo full flag
//   busy       out  1 while a grant is active
// -----------------------------------------------------------------------------
module fifo_push_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BITS      = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*BITS-1:0]  din,
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       grant,
  output logic                   fifo_push,
  output logic [BITS-1:0]        fifo_din,
  input  logic                   fifo_full,
  output logic                   busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  // last_q is the most recent winner; it doubles as the owner index in BURST.
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]   winner_s;
  logic [IDX_W-1:0]   cand_s;
  logic               found_s;
  logic               owner_req_s;
  logic               accept_s;

  // The owner still requests, and the fifo can take the word.
  assign owner_req_s = |(req & grant_q);
  assign accept_s    = (state_q == ST_BURST) & owner_req_s & ~fifo_full;

  // Round-robin search: the first requester after last_q (mod N_REQ) wins.
  always_comb begin
    winner_s = last_q;
    found_s  = 1'b0;
    cand_s   = last_q;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = IDX_W'((32'(last_q) + 32'(k)) % 32'(N_REQ));
      if (!found_s && req[cand_s]) begin
        winner_s = cand_s;
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Fifo write port and acks. These are combinational and forced to zero outside BURST.
  always_comb begin
    ack       = {N_REQ{1'b0}};
    fifo_push = 1'b0;
    fifo_din  = {BITS{1'b0}};
    if (state_q == ST_BURST) begin
      fifo_din  = din[last_q*BITS +: BITS];
      fifo_push = accept_s;
      ack       = accept_s ? grant_q : {N_REQ{1'b0}};
    end else begin
      fifo_push = 1'b0;
    end
  end

  // Next-state logic for arbitration and burst accounting.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // Fifo full does not hold back arbitration; the owner stalls in BURST instead.
        if (|req) begin
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
          last_d  = winner_s;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_BURST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (!owner_req_s) begin
          // The owner withdrew. Release the port without a push.
          state_d = ST_IDLE;
          grant_d = {N_REQ{1'b0}};
        end else if (fifo_full) begin
          // Stall: keep the grant and the count unchanged.
          state_d = ST_BURST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = ST_IDLE;
            grant_d = {N_REQ{1'b0}};
          end else begin
            state_d = ST_BURST;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {N_REQ{1'b0}};
      end
    endcase
  end

  // State registers. After reset last_q = N_REQ-1, so producer 0 is scanned first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= {N_REQ{1'b0}};
      last_q  <= IDX_W'(N_REQ - 1);
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;

  localparam int N  = 4;
  localparam int B  = 8;
  localparam int MB = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*B-1:0]  din;
  logic [N-1:0]    ack;
  logic [N-1:0]    grant;
  logic            fifo_push;
  logic [B-1:0]    fifo_din;
  logic            fifo_full;
  logic            busy;

  int n_pass  = 0;
  int n_total = 0;

  fifo_push_arbiter #(.N_REQ(N), .BITS(B), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .grant     (grant),
    .fifo_push (fifo_push),
    .fifo_din  (fifo_din),
    .fifo_full (fifo_full),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Packed view of the outputs: {grant, ack, push, fifo_din, busy}.
  function automatic logic [31:0] pk(input logic [3:0] g, input logic [3:0] a,
                                     input logic p, input logic [7:0] d, input logic b);
    return {14'd0, g, a, p, d, b};
  endfunction

  function automatic logic [31:0] dut_pk();
    return {14'd0, grant, ack, fifo_push, fifo_din, busy};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  // Starts at posedge+1. Drives the inputs, checks at the negedge, and ends at the next posedge+1.
  task automatic run_cycle(input string nm, input logic [3:0] r, input logic f,
                           input logic [31:0] d, input logic [31:0] exp);
    req = r; fifo_full = f; din = d;
    @(negedge clk);
    chk(nm, dut_pk(), exp);
    @(posedge clk); #1;
  endtask

  // Reference model state: owner (-1 = none), words taken this grant, last winner.
  int m_owner, m_taken, m_last;

  task automatic do_reset();
    req = 4'b0000; fifo_full = 1'b0; din = 32'h0000_0000;
    rst = 1'b0;
    m_owner = -1; m_taken = 0; m_last = N - 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic        full;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[15];

  localparam logic [31:0] DIN_ALL = 32'hD3C2_B1A0;

  logic [3:0] p_req;
  int         seq[N];
  int         pushed_seq[N];
  logic [3:0] ack_prev;
  int         words_in, words_pushed;

  initial begin
    logic [3:0] eg, ea;
    logic       ep, eb, full_v, inv_ok;
    logic [7:0] ed;
    logic [31:0] dv;
    int p;

    // T1 plus a stall at grant time: {req, full, din, expected outputs}.
    tbl[0]  = '{4'b0001, 1'b0, 32'h0000_00A0, pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0)};
    tbl[1]  = '{4'b0001, 1'b0, 32'h0000_00A0, pk(4'h1, 4'h1, 1'b1, 8'hA0, 1'b1)};
    tbl[2]  = '{4'b0001, 1'b0, 32'h0000_00A1, pk(4'h1, 4'h1, 1'b1, 8'hA1, 1'b1)};
    tbl[3]  = '{4'b0001, 1'b0, 32'h0000_00A2, pk(4'h1, 4'h1, 1'b1, 8'hA2, 1'b1)};
    tbl[4]  = '{4'b0001, 1'b0, 32'h0000_00A3, pk(4'h1, 4'h1, 1'b1, 8'hA3, 1'b1)};
    tbl[5]  = '{4'b0001, 1'b0, 32'h0000_00A4, pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0)};
    tbl[6]  = '{4'b0001, 1'b0, 32'h0000_00A4, pk(4'h1, 4'h1, 1'b1, 8'hA4, 1'b1)};
    tbl[7]  = '{4'b0001, 1'b0, 32'h0000_00A5, pk(4'h1, 4'h1, 1'b1, 8'hA5, 1'b1)};
    tbl[8]  = '{4'b0000, 1'b0, 32'h0000_0000, pk(4'h1, 4'h0, 1'b0, 8'h00, 1'b1)};
    tbl[9]  = '{4'b0000, 1'b0, 32'h0000_0000, pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0)};
    tbl[10] = '{4'b0001, 1'b1, 32'h0000_00B0, pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0)};
    tbl[11] = '{4'b0001, 1'b1, 32'h0000_00B0, pk(4'h1, 4'h0, 1'b0, 8'hB0, 1'b1)};
    tbl[12] = '{4'b0001, 1'b0, 32'h0000_00B0, pk(4'h1, 4'h1, 1'b1, 8'hB0, 1'b1)};
    tbl[13] = '{4'b0000, 1'b0, 32'h0000_0000, pk(4'h1, 4'h0, 1'b0, 8'h00, 1'b1)};
    tbl[14] = '{4'b0000, 1'b0, 32'h0000_0000, pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0)};

    // Reset state.
    do_reset();
    @(negedge clk);
    chk("reset_state", dut_pk(), pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0));
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++)
      run_cycle($sformatf("t1_row%0d", i), tbl[i].req, tbl[i].full, tbl[i].din, tbl[i].exp);

    // T2: all request, with grants in rotation and one bubble between grants.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      run_cycle($sformatf("t2_bubble%0d", g), 4'hF, 1'b0, DIN_ALL, pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0));
      for (int w = 0; w < MB; w++) begin
        dv = DIN_ALL >> ((g % N) * B);
        run_cycle($sformatf("t2_g%0d_w%0d", g, w), 4'hF, 1'b0, DIN_ALL,
                  pk(4'(1 << (g % N)), 4'(1 << (g % N)), 1'b1, dv[7:0], 1'b1));
      end
    end

    // T3: owner 2 stalls by full mid-burst, then finishes the remaining two words.
    do_reset();
    run_cycle("t3_idle", 4'b0100, 1'b0, DIN_ALL, pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0));
    for (int w = 0; w < 2; w++)
      run_cycle($sformatf("t3_pre%0d", w), 4'b0100, 1'b0, DIN_ALL, pk(4'h4, 4'h4, 1'b1, 8'hC2, 1'b1));
    for (int s = 0; s < 5; s++)
      run_cycle($sformatf("t3_stall%0d", s), 4'b0100, 1'b1, DIN_ALL, pk(4'h4, 4'h0, 1'b0, 8'hC2, 1'b1));
    for (int w = 0; w < 2; w++)
      run_cycle($sformatf("t3_post%0d", w), 4'b0100, 1'b0, DIN_ALL, pk(4'h4, 4'h4, 1'b1, 8'hC2, 1'b1));
    run_cycle("t3_end_idle", 4'b0100, 1'b0, DIN_ALL, pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0));

    // T4: owner 1 withdraws, and round-robin from last=1 picks producer 3 over 0.
    do_reset();
    run_cycle("t4_idle", 4'b0010, 1'b0, DIN_ALL, pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0));
    run_cycle("t4_push", 4'b0010, 1'b0, DIN_ALL, pk(4'h2, 4'h2, 1'b1, 8'hB1, 1'b1));
    run_cycle("t4_drop", 4'b1001, 1'b0, DIN_ALL, pk(4'h2, 4'h0, 1'b0, 8'hB1, 1'b1));
    run_cycle("t4_bubble", 4'b1001, 1'b0, DIN_ALL, pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0));
    run_cycle("t4_rr", 4'b1001, 1'b0, DIN_ALL, pk(4'h8, 4'h8, 1'b1, 8'hD3, 1'b1));

    // T5: asynchronous reset mid-burst.
    do_reset();
    run_cycle("t5_idle", 4'hF, 1'b0, DIN_ALL, pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0));
    run_cycle("t5_grant", 4'hF, 1'b0, DIN_ALL, pk(4'h1, 4'h1, 1'b1, 8'hA0, 1'b1));
    @(negedge clk); #1 rst = 1'b0;
    #1 chk("t5_async", dut_pk(), pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0));
    @(posedge clk); #1 chk("t5_held", dut_pk(), pk(4'h0, 4'h0, 1'b0, 8'h00, 1'b0));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    run_cycle("t5_after", 4'hF, 1'b0, DIN_ALL, pk(4'h1, 4'h1, 1'b1, 8'hA0, 1'b1));

    // T6: random producers and back-pressure against the reference model.
    do_reset();
    p_req = 4'b0000; ack_prev = 4'b0000; words_in = 0; words_pushed = 0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; pushed_seq[i] = 0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      // Producers keep their word until acked, and sometimes withdraw it.
      for (int i = 0; i < N; i++) begin
        if (ack_prev[i]) begin
          seq[i]++;
          p_req[i] = ($urandom_range(0, 1) == 1);
        end else if (p_req[i]) begin
          if ($urandom_range(0, 19) == 0) p_req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          p_req[i] = 1'b1;
        end
        dv[i*B +: B] = 8'((i << 6) | (seq[i] & 63));
      end
      full_v = ($urandom_range(0, 3) == 0);
      req = p_req; fifo_full = full_v; din = dv;
      @(negedge clk);

      eg = 4'h0; ea = 4'h0; ep = 1'b0; ed = 8'h00; eb = 1'b0;
      if (m_owner >= 0) begin
        eg = 4'(1 << m_owner);
        ep = req[m_owner] && !full_v;
        ea = ep ? eg : 4'h0;
        ed = din[m_owner*B +: B];
        eb = 1'b1;
      end
      chk("rand_out", dut_pk(), pk(eg, ea, ep, ed, eb));

      inv_ok = ($countones(grant) <= 1) && ($countones(ack) <= 1) &&
               (fifo_push == |ack) && !(fifo_push && fifo_full);
      chk("rand_invariants", 32'(inv_ok), 32'd1);

      if (fifo_push === 1'b1) begin
        p = int'(fifo_din[7:6]);
        chk("rand_order", 32'(fifo_din[5:0]), 32'(pushed_seq[p] & 63));
        pushed_seq[p]++;
        words_pushed++;
      end
      if (ep) words_in++;

      // Advance the model by the arbitration rules.
      if (m_owner < 0) begin
        if (req != 4'b0000) begin
          for (int k = 1; k <= N; k++) begin
            if (m_owner < 0 && req[(m_last + k) % N]) begin
              m_owner = (m_last + k) % N;
              m_last  = m_owner;
              m_taken = 0;
            end
          end
        end
      end else if (!req[m_owner]) begin
        m_owner = -1;
      end else if (!full_v) begin
        m_taken++;
        if (m_taken == MB) m_owner = -1;
      end
      ack_prev = ea;
      @(posedge clk); #1;
    end
    chk("words_in_eq_pushed", 32'(words_pushed), 32'(words_in));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
